// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC 3-wire SPI configuration master.
// Readback support is controlled by the ADC_SPI_READBACK_EN macro.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned INSTR_BITS = 16;
    localparam int unsigned DATA_BITS  = FRAME_BITS - INSTR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [3:0] REG_CTRL    = 4'd0;
    localparam logic [3:0] REG_ADDR_HI = 4'd1;
    localparam logic [3:0] REG_ADDR_LO = 4'd2;
    localparam logic [3:0] REG_WDATA   = 4'd3;
    localparam logic [3:0] REG_RDATA   = 4'd4;
    localparam logic [3:0] REG_STATUS  = 4'd5;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_RNW   = 1;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

endpackage

// File: rtl/adc_spi_shifter.sv
// Frame shifter: 24-bit parallel load / MSB-first shift-out, plus an 8-bit
// shift-in capture register built only when ADC_SPI_READBACK_EN is defined.
module adc_spi_shifter
    import adc_spi_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_load_word,
    input  logic                  i_shift_en,
    input  logic                  i_sample_en,
    input  logic                  i_sdio_in,
    output logic                  o_sdio_out,
    output logic [DATA_BITS-1:0]  o_rx_byte
);

    logic [FRAME_BITS-1:0] r_tx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx <= '0;
        end else if (i_load) begin
            r_tx <= i_load_word;
        end else if (i_shift_en) begin
            r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign o_sdio_out = r_tx[FRAME_BITS-1];

`ifdef ADC_SPI_READBACK_EN
    logic [DATA_BITS-1:0] r_rx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx <= '0;
        end else if (i_sample_en) begin
            r_rx <= {r_rx[DATA_BITS-2:0], i_sdio_in};
        end
    end

    assign o_rx_byte = r_rx;
`else
    logic w_unused_in;
    assign w_unused_in = i_sample_en ^ i_sdio_in;
    assign o_rx_byte   = '0;
`endif

endmodule

// File: rtl/adc_spi_config_master.sv
// Avalon-MM controlled SPI master for the ADC 3-wire configuration port.
// Read frames (SDIO turnaround and RDATA capture) exist only with ADC_SPI_READBACK_EN.
module adc_spi_config_master
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned GAP_HALFS = 2
) (
    input  logic       main_clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       ADC_CSBn,
    output logic       ADC_SCLK,
    output logic       ADC_SDIO_OUT,
    output logic       ADC_SDIO_OE,
    input  logic       ADC_SDIO_IN,
    output logic       irq
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_HALFS - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [4:0] OE_BIT   = 5'(INSTR_BITS - 1);

    state_t                r_state, w_next;
    logic [7:0]            r_div, r_gap;
    logic [4:0]            r_bit_cnt;
    logic                  r_sclk, r_csbn, r_done, r_err;
    logic [4:0]            r_addr_hi;
    logic [7:0]            r_addr_lo, r_wdata, r_readdata;
    logic [7:0]            w_rd_mux, w_status, w_rdata;
    logic [DATA_BITS-1:0]  w_rx_byte;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_idle, w_half_end, w_start, w_load, w_req_rnw, w_rnw;
    logic                  w_frame_end, w_shift_en, w_sample_en;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_half_end  = (r_div == DIV_LAST);
    assign w_start     = write && (address == REG_CTRL) && writedata[CTRL_START];
    assign w_load      = w_start && w_idle;
    assign w_frame     = {w_req_rnw, 2'b00, r_addr_hi, r_addr_lo, r_wdata};
    assign w_frame_end = !w_idle && (w_next == ST_IDLE);

    always_ff @(posedge main_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // SCLK high half-periods end with a falling edge (present next bit);
    // low half-periods end with a rising edge (ADC and capture sample).
    always_comb begin
        w_next      = r_state;
        w_shift_en  = 1'b0;
        w_sample_en = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_load) w_next = ST_SETUP;
            ST_SETUP: if (w_half_end) w_next = ST_SHIFT;
            ST_SHIFT: begin
                w_shift_en  = w_half_end && r_sclk && (r_bit_cnt != LAST_BIT);
                w_sample_en = w_half_end && !r_sclk && (r_bit_cnt >= OE_BIT) &&
                              (r_bit_cnt != LAST_BIT);
                if (w_half_end && !r_sclk && (r_bit_cnt == LAST_BIT)) w_next = ST_HOLD;
            end
            ST_HOLD:  if (w_half_end) w_next = (GAP_HALFS == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_half_end && (r_gap == GAP_LAST)) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (rst) begin
            r_div      <= '0;
            r_gap      <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_csbn     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_addr_hi  <= '0;
            r_addr_lo  <= '0;
            r_wdata    <= '0;
            r_readdata <= '0;
        end else begin
            r_div <= (w_idle || w_half_end) ? '0 : r_div + 8'd1;

            if (w_idle) r_bit_cnt <= '0;
            else if (r_state == ST_SHIFT && w_half_end && !r_sclk && r_bit_cnt != LAST_BIT)
                r_bit_cnt <= r_bit_cnt + 5'd1;

            if (r_state != ST_GAP) r_gap <= '0;
            else if (w_half_end)   r_gap <= r_gap + 8'd1;

            if (r_state == ST_SETUP && w_half_end)      r_sclk <= 1'b1;
            else if (r_state == ST_SHIFT && w_half_end) r_sclk <= !r_sclk && (r_bit_cnt != LAST_BIT);

            if (w_load)                            r_csbn <= 1'b0;
            else if (r_state == ST_HOLD && w_half_end) r_csbn <= 1'b1;

            if (w_frame_end) r_done <= 1'b1;
            else if (write && address == REG_STATUS && writedata[STAT_DONE]) r_done <= 1'b0;

            if (w_start && !w_idle) r_err <= 1'b1;
            else if (write && address == REG_STATUS && writedata[STAT_ERR]) r_err <= 1'b0;

            if (write && w_idle) begin
                case (address)
                    REG_ADDR_HI: r_addr_hi <= writedata[4:0];
                    REG_ADDR_LO: r_addr_lo <= writedata;
                    REG_WDATA:   r_wdata   <= writedata;
                    default: ;
                endcase
            end

            r_readdata <= read ? w_rd_mux : '0;
        end
    end

`ifdef ADC_SPI_READBACK_EN
    logic       r_rnw, r_frame_rnw, r_oe;
    logic [7:0] r_rdata;

    assign w_req_rnw = writedata[CTRL_RNW];

    always_ff @(posedge main_clk) begin
        if (rst) begin
            r_rnw       <= 1'b0;
            r_frame_rnw <= 1'b0;
            r_oe        <= 1'b1;
            r_rdata     <= '0;
        end else begin
            if (write && address == REG_CTRL && w_idle) r_rnw <= writedata[CTRL_RNW];
            if (w_load) r_frame_rnw <= w_req_rnw;
            if (r_state == ST_SHIFT && w_half_end && r_sclk && r_bit_cnt == OE_BIT && r_frame_rnw)
                r_oe <= 1'b0;
            else if (r_state == ST_HOLD && w_half_end)
                r_oe <= 1'b1;
            if (r_state == ST_HOLD && w_half_end && r_frame_rnw) r_rdata <= w_rx_byte;
        end
    end

    assign w_rnw       = r_rnw;
    assign w_rdata     = r_rdata;
    assign ADC_SDIO_OE = r_oe;
`else
    logic [DATA_BITS-1:0] w_unused_rx;
    assign w_unused_rx = w_rx_byte;
    assign w_req_rnw   = 1'b0;
    assign w_rnw       = 1'b0;
    assign w_rdata     = '0;
    assign ADC_SDIO_OE = 1'b1;
`endif

    always_comb begin
        w_status            = '0;
        w_status[STAT_BUSY] = !w_idle;
        w_status[STAT_DONE] = r_done;
        w_status[STAT_ERR]  = r_err;
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            REG_CTRL:    w_rd_mux = {7'b0, w_rnw};
            REG_ADDR_HI: w_rd_mux = {3'b0, r_addr_hi};
            REG_ADDR_LO: w_rd_mux = r_addr_lo;
            REG_WDATA:   w_rd_mux = r_wdata;
            REG_RDATA:   w_rd_mux = w_rdata;
            REG_STATUS:  w_rd_mux = w_status;
            default:     w_rd_mux = '0;
        endcase
    end

    adc_spi_shifter u_shifter (
        .i_clk       (main_clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_load_word (w_frame),
        .i_shift_en  (w_shift_en),
        .i_sample_en (w_sample_en),
        .i_sdio_in   (ADC_SDIO_IN),
        .o_sdio_out  (ADC_SDIO_OUT),
        .o_rx_byte   (w_rx_byte)
    );

    assign readdata = r_readdata;
    assign ADC_CSBn = r_csbn;
    assign ADC_SCLK = r_sclk;
    assign irq      = r_done;

endmodule
